// File: rtl/regfile_dump_reader.sv
// Walks register addresses 0..NUM_REGS-1 through a borrowed register-file read port
// and streams each (address, data) pair over a valid/ready interface.
//
// state | meaning
// IDLE  | waiting for start; outputs idle
// FETCH | rf_address = idx, capture rf_data into the output word on the edge
// SEND  | output word valid, waiting for out_ready (or abort)
module regfile_dump_reader #(
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rf_address,
    input  logic [DATA_WIDTH-1:0] rf_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_address,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] SEND  = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] idx;

    assign busy       = (state != IDLE);
    assign rf_address = idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            done        <= 1'b0;
            out_valid   <= 1'b0;
            out_address <= '0;
            out_data    <= '0;
            out_last    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // abort wins over a simultaneous start
                    if (start && !abort) begin
                        idx   <= '0;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        out_data    <= rf_data;
                        out_address <= idx;
                        out_valid   <= 1'b1;
                        out_last    <= (idx == LAST_IDX);
                        state       <= SEND;
                    end
                end
                SEND: begin
                    // abort beats a same-cycle handshake: the word is treated as not accepted
                    if (abort) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        state     <= IDLE;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (idx == LAST_IDX) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            idx   <= idx + ADDR_WIDTH'(1);
                            state <= FETCH;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: a 32-register and a 4-register instance checked every
// cycle against a transaction-level model, plus directed cycle-count expectations.
module tb_regfile_dump_reader;

    localparam int N0 = 32;
    localparam int N1 = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] start     = 2'b00;
    logic [1:0] abort     = 2'b00;
    logic [1:0] out_ready = 2'b11;
    logic [1:0] busy, done, out_valid, out_last;

    logic [4:0]  rf_addr0, addr0;
    logic [1:0]  rf_addr1, addr1;
    logic [31:0] rf_data0, rf_data1, data0, data1;

    logic [31:0] regs [32];

    int checks = 0;
    int errors = 0;

    initial begin
        regs[0] = 32'h0;
        for (int k = 1; k < 32; k++) regs[k] = 32'h1000_0000 + k;
    end

    assign rf_data0 = regs[rf_addr0];
    assign rf_data1 = regs[{3'b000, rf_addr1}];

    regfile_dump_reader #(.NUM_REGS(N0), .ADDR_WIDTH(5), .DATA_WIDTH(32)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
        .busy(busy[0]), .done(done[0]), .rf_address(rf_addr0), .rf_data(rf_data0),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_address(addr0),
        .out_data(data0), .out_last(out_last[0])
    );

    regfile_dump_reader #(.NUM_REGS(N1), .ADDR_WIDTH(2), .DATA_WIDTH(32)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
        .busy(busy[1]), .done(done[1]), .rf_address(rf_addr1), .rf_data(rf_data1),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_address(addr1),
        .out_data(data1), .out_last(out_last[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int cur_addr(input int d);
        return (d == 1) ? int'(addr1) : int'(addr0);
    endfunction

    function automatic logic [31:0] cur_data(input int d);
        return (d == 1) ? data1 : data0;
    endfunction

    function automatic logic [31:0] exp_data(input int k);
        return (k == 0) ? 32'h0 : 32'h1000_0000 + k;
    endfunction

    // Transaction-level model: which word should be on the bus, and when.
    int m_idx [2];
    bit m_busy [2], m_valid [2], m_done [2];
    bit p_acc [2], p_abort [2], p_ready [2];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int n;
            n = (d == 1) ? N1 : N0;
            if (!rst_n) begin
                m_idx[d] = 0; m_busy[d] = 0; m_valid[d] = 0; m_done[d] = 0;
                p_acc[d] = 0; p_abort[d] = 0; p_ready[d] = 0;
                chk($sformatf("rst_busy%0d", d), 64'(busy[d]), 64'd0);
                chk($sformatf("rst_valid%0d", d), 64'(out_valid[d]), 64'd0);
                chk($sformatf("rst_done%0d", d), 64'(done[d]), 64'd0);
                chk($sformatf("rst_addr%0d", d), 64'(cur_addr(d)), 64'd0);
            end else begin
                m_done[d] = 0;
                if (p_acc[d]) begin
                    m_busy[d] = 1; m_valid[d] = 0; m_idx[d] = 0;
                end else if (m_busy[d] && p_abort[d]) begin
                    m_busy[d] = 0; m_valid[d] = 0;
                end else if (m_busy[d] && !m_valid[d]) begin
                    m_valid[d] = 1;
                end else if (m_valid[d] && p_ready[d]) begin
                    m_valid[d] = 0;
                    if (m_idx[d] == n - 1) begin
                        m_busy[d] = 0; m_done[d] = 1;
                    end else begin
                        m_idx[d]++;
                    end
                end
                chk($sformatf("busy%0d", d), 64'(busy[d]), 64'(m_busy[d]));
                chk($sformatf("valid%0d", d), 64'(out_valid[d]), 64'(m_valid[d]));
                chk($sformatf("done%0d", d), 64'(done[d]), 64'(m_done[d]));
                chk($sformatf("last%0d", d), 64'(out_last[d]),
                    64'(m_valid[d] && (m_idx[d] == n - 1)));
                if (m_valid[d]) begin
                    chk($sformatf("addr%0d", d), 64'(cur_addr(d)), 64'(m_idx[d]));
                    chk($sformatf("data%0d", d), 64'(cur_data(d)), 64'(exp_data(m_idx[d])));
                end
                p_acc[d]   = !m_busy[d] && start[d] && !abort[d];
                p_abort[d] = abort[d];
                p_ready[d] = out_ready[d];
            end
        end
    end

    // start is raised in cycle 0; returns with the done cycle, first valid cycle, word count.
    task automatic run_dump(input int d, input int bp_at, input int bp_len, input bit hold,
                            output int done_cyc, output int first_v, output int words);
        int bp_left;
        bit bp_seen;
        bp_left = 0; bp_seen = 0;
        done_cyc = -1; first_v = -1; words = 0;
        @(posedge clk); #1;
        start[d] = 1'b1;
        out_ready[d] = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
                if (!hold) start[d] = 1'b0;
            end
            if (done[d]) begin
                done_cyc = cyc;
                break;
            end
            if (out_valid[d]) begin
                if (first_v < 0) first_v = cyc;
                if (!bp_seen && cur_addr(d) == bp_at) begin
                    bp_seen = 1; bp_left = bp_len;
                end
                if (bp_left > 0) begin
                    out_ready[d] = 1'b0;
                    bp_left--;
                end else begin
                    out_ready[d] = 1'b1;
                    words++;
                end
            end
        end
        out_ready[d] = 1'b1;
        if (done_cyc < 0) begin
            checks++; errors++;
            $display("FAIL dump_timeout: no done within 400 cycles (inst %0d)", d);
        end
    endtask

    task automatic wait_word(input int d, input int target, output bit found);
        found = 0;
        @(posedge clk); #1;
        start[d] = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            start[d] = 1'b0;
            if (out_valid[d] && cur_addr(d) == target) begin
                found = 1;
                break;
            end
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL wait_word_timeout: word %0d never valid (inst %0d)", target, d);
        end
    endtask

    initial begin
        int dc, fv, nw;
        bit found;

        #12;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_last", 64'(out_last), 64'd0);
        chk("reset_data0", 64'(data0), 64'd0);
        chk("reset_rf_addr0", 64'(rf_addr0), 64'd0);
        #10 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_dump(0, -1, 0, 1'b0, dc, fv, nw);
        chk("full_done_cycle", 64'(dc), 64'd65);
        chk("full_first_valid", 64'(fv), 64'd2);
        chk("full_words", 64'(nw), 64'd32);

        run_dump(0, 7, 5, 1'b0, dc, fv, nw);
        chk("bp_done_cycle", 64'(dc), 64'd70);
        chk("bp_words", 64'(nw), 64'd32);

        wait_word(0, 10, found);
        out_ready[0] = 1'b1;
        abort[0] = 1'b1;
        @(posedge clk); #1;
        abort[0] = 1'b0;
        chk("abort_busy", 64'(busy[0]), 64'd0);
        chk("abort_valid", 64'(out_valid[0]), 64'd0);
        chk("abort_done", 64'(done[0]), 64'd0);
        @(posedge clk); #1;
        chk("abort_done_next", 64'(done[0]), 64'd0);
        run_dump(0, -1, 0, 1'b0, dc, fv, nw);
        chk("after_abort_done_cycle", 64'(dc), 64'd65);
        chk("after_abort_first_valid", 64'(fv), 64'd2);

        run_dump(0, -1, 0, 1'b1, dc, fv, nw);
        chk("held_done_cycle", 64'(dc), 64'd65);
        chk("held_words", 64'(nw), 64'd32);
        @(posedge clk); #1;
        start[0] = 1'b0;
        chk("held_restart_busy", 64'(busy[0]), 64'd1);
        chk("held_restart_fetch_valid", 64'(out_valid[0]), 64'd0);
        @(posedge clk); #1;
        chk("held_restart_valid", 64'(out_valid[0]), 64'd1);
        chk("held_restart_addr", 64'(addr0), 64'd0);
        abort[0] = 1'b1;
        @(posedge clk); #1;
        abort[0] = 1'b0;
        chk("held_abort_busy", 64'(busy[0]), 64'd0);

        wait_word(0, 20, found);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy[0]), 64'd0);
        chk("midrst_valid", 64'(out_valid[0]), 64'd0);
        chk("midrst_addr", 64'(addr0), 64'd0);
        chk("midrst_data", 64'(data0), 64'd0);
        chk("midrst_last", 64'(out_last[0]), 64'd0);
        chk("midrst_done", 64'(done[0]), 64'd0);
        chk("midrst_rf_addr", 64'(rf_addr0), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        run_dump(0, -1, 0, 1'b0, dc, fv, nw);
        chk("after_rst_done_cycle", 64'(dc), 64'd65);
        chk("after_rst_words", 64'(nw), 64'd32);

        run_dump(1, -1, 0, 1'b0, dc, fv, nw);
        chk("n4_done_cycle", 64'(dc), 64'd9);
        chk("n4_first_valid", 64'(fv), 64'd2);
        chk("n4_words", 64'(nw), 64'd4);

        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
